// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, flag layout, operand classes
// and helpers for the special encodings of a given format.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FL_NV = 4;
    localparam int FL_DZ = 3;
    localparam int FL_OF = 2;
    localparam int FL_UF = 1;
    localparam int FL_NX = 0;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } cls_t;

    // Encodings are built in 64 bits; callers truncate to their width.
    function automatic logic [63:0] fp_qnan(input int ew, input int mw);
        fp_qnan = (((64'd1 << ew) - 64'd1) << mw)
                | (64'd1 << (mw - 1));
    endfunction

    function automatic logic [63:0] fp_maxf(input int ew, input int mw);
        fp_maxf = (((64'd1 << ew) - 64'd2) << mw)
                | ((64'd1 << mw) - 64'd1);
    endfunction

endpackage

// File: rtl/fpu_round.sv
// Rounding increment for a truncated fraction with guard and sticky,
// reporting the carry out of the fraction field.
module fpu_round #(
    parameter int MAN_W = 23
) (
    input  logic             i_sign,
    input  logic [MAN_W-1:0] i_frac,
    input  logic             i_guard,
    input  logic             i_sticky,
    input  logic [2:0]       i_rm,
    output logic [MAN_W-1:0] o_frac,
    output logic             o_carry
);
    import fpu_pkg::*;

    logic w_up;

    always_comb begin
        w_up = 1'b0;
        unique case (i_rm)
            RM_RTZ:  w_up = 1'b0;
            RM_RDN:  w_up = i_sign & (i_guard | i_sticky);
            RM_RUP:  w_up = ~i_sign & (i_guard | i_sticky);
            RM_RMM:  w_up = i_guard;
            default: w_up = i_guard & (i_sticky | i_frac[0]);
        endcase
    end

    assign {o_carry, o_frac} = {1'b0, i_frac} + (MAN_W + 1)'(w_up);

endmodule

// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754 divider: radix-2 restoring mantissa division,
// one quotient bit per clock, DAZ/FTZ, all RISC-V rounding modes.
module fpu_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [2:0]           rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [4:0]           flags
);
    import fpu_pkg::*;

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW2   = EXP_W + 2;
    localparam int BIAS  = (2 ** (EXP_W - 1)) - 1;
    localparam int DIV_N = MAN_W + 2;
    localparam int CW    = $clog2(DIV_N + 1);

    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-2:0] MAXF = (W - 1)'(fp_maxf(EXP_W, MAN_W));
    localparam logic signed [EW2-1:0] EMAX = EW2'((2 ** EXP_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_rnd_ph;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_rm;
    logic                  r_sign;
    logic signed [EW2-1:0] r_exp;
    logic [MAN_W+1:0]      r_rem;
    logic [MAN_W:0]        r_div;
    logic [MAN_W:0]        r_q;
    logic                  r_special;
    logic [W-1:0]          r_sres;
    logic [4:0]            r_sflg;
    logic [MAN_W-1:0]      r_rfrac;
    logic                  r_rcarry;
    logic                  r_inexact;
    logic [W-1:0]          r_result;
    logic [4:0]            r_flags;
    logic                  r_out_valid;
    logic                  r_in_ready;

    function automatic cls_t classify(
        input logic [EXP_W-1:0] e,
        input logic [MAN_W-1:0] f
    );
        if (e == '0)
            classify = CLS_ZERO;
        else if (e != '1)
            classify = CLS_NORM;
        else if (f == '0)
            classify = CLS_INF;
        else if (f[MAN_W-1])
            classify = CLS_QNAN;
        else
            classify = CLS_SNAN;
    endfunction

    logic [EXP_W-1:0]      w_ea;
    logic [EXP_W-1:0]      w_eb;
    logic [MAN_W:0]        w_ma;
    logic [MAN_W:0]        w_mb;
    logic                  w_pre;
    logic                  w_sign;
    logic signed [EW2-1:0] w_e0;
    cls_t                  w_ca;
    cls_t                  w_cb;

    assign w_ea   = a[W-2 -: EXP_W];
    assign w_eb   = b[W-2 -: EXP_W];
    assign w_ma   = {1'b1, a[MAN_W-1:0]};
    assign w_mb   = {1'b1, b[MAN_W-1:0]};
    assign w_pre  = w_ma < w_mb;
    assign w_sign = a[W-1] ^ b[W-1];
    assign w_ca   = classify(w_ea, a[MAN_W-1:0]);
    assign w_cb   = classify(w_eb, b[MAN_W-1:0]);
    assign w_e0   = EW2'(w_ea) - EW2'(w_eb) + EW2'(BIAS) - EW2'(w_pre);

    logic         w_nan_a;
    logic         w_nan_b;
    logic         w_snan;
    logic         w_zz;
    logic         w_ii;
    logic         w_spec;
    logic [W-1:0] w_sres;
    logic [4:0]   w_sflg;
    logic [W-1:0] w_sinf;
    logic [W-1:0] w_szero;

    assign w_nan_a = (w_ca == CLS_QNAN) || (w_ca == CLS_SNAN);
    assign w_nan_b = (w_cb == CLS_QNAN) || (w_cb == CLS_SNAN);
    assign w_snan  = (w_ca == CLS_SNAN) || (w_cb == CLS_SNAN);
    assign w_zz    = (w_ca == CLS_ZERO) && (w_cb == CLS_ZERO);
    assign w_ii    = (w_ca == CLS_INF) && (w_cb == CLS_INF);
    assign w_sinf  = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign w_szero = {w_sign, {(W - 1){1'b0}}};

    // Special operands resolved at accept, in priority order.
    always_comb begin
        w_spec = 1'b1;
        w_sres = QNAN;
        w_sflg = '0;
        if (w_nan_a || w_nan_b || w_zz || w_ii) begin
            w_sflg[FL_NV] = w_snan | w_zz | w_ii;
        end else if (w_ca == CLS_NORM && w_cb == CLS_ZERO) begin
            w_sres        = w_sinf;
            w_sflg[FL_DZ] = 1'b1;
        end else if (w_ca == CLS_INF) begin
            w_sres = w_sinf;
        end else if (w_cb == CLS_INF || w_ca == CLS_ZERO) begin
            w_sres = w_szero;
        end else begin
            w_spec = 1'b0;
        end
    end

    logic           w_ge;
    logic [MAN_W:0] w_sub;
    logic [MAN_W:0] w_nrem;

    assign w_ge   = r_rem >= {1'b0, r_div};
    assign w_sub  = r_rem[MAN_W:0] - r_div;
    assign w_nrem = w_ge ? w_sub : r_rem[MAN_W:0];

    logic [MAN_W-1:0] w_rfrac;
    logic             w_rcarry;
    logic             w_sticky;

    assign w_sticky = |r_rem;

    fpu_round #(
        .MAN_W (MAN_W)
    ) u_round (
        .i_sign   (r_sign),
        .i_frac   (r_q[MAN_W:1]),
        .i_guard  (r_q[0]),
        .i_sticky (w_sticky),
        .i_rm     (r_rm),
        .o_frac   (w_rfrac),
        .o_carry  (w_rcarry)
    );

    logic signed [EW2-1:0] w_efin;
    logic                  w_of;
    logic                  w_uf;
    logic [W-1:0]          w_inf;
    logic [W-1:0]          w_max;
    logic [W-1:0]          w_pres;
    logic [4:0]            w_pflg;

    assign w_efin = r_exp + EW2'(r_rcarry);
    assign w_of   = w_efin >= EMAX;
    assign w_uf   = w_efin[EW2-1] | (w_efin == '0);
    assign w_inf  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign w_max  = {r_sign, MAXF};

    always_comb begin
        w_pres        = {r_sign, w_efin[EXP_W-1:0], r_rfrac};
        w_pflg        = '0;
        w_pflg[FL_NX] = r_inexact;
        if (r_special) begin
            w_pres = r_sres;
            w_pflg = r_sflg;
        end else if (w_of) begin
            w_pflg[FL_OF] = 1'b1;
            w_pflg[FL_NX] = 1'b1;
            unique case (r_rm)
                RM_RTZ:  w_pres = w_max;
                RM_RDN:  w_pres = r_sign ? w_inf : w_max;
                RM_RUP:  w_pres = r_sign ? w_max : w_inf;
                default: w_pres = w_inf;
            endcase
        end else if (w_uf) begin
            w_pres        = {r_sign, {(W - 1){1'b0}}};
            w_pflg[FL_UF] = 1'b1;
            w_pflg[FL_NX] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rnd_ph    <= 1'b0;
            r_cnt       <= '0;
            r_rm        <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q         <= '0;
            r_special   <= 1'b0;
            r_sres      <= '0;
            r_sflg      <= '0;
            r_rfrac     <= '0;
            r_rcarry    <= 1'b0;
            r_inexact   <= 1'b0;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_rnd_ph    <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state    <= S_DIV;
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        r_rm       <= rm;
                        r_sign     <= w_sign;
                        r_exp      <= w_e0;
                        r_rem      <= w_pre ? {w_ma, 1'b0} : {1'b0, w_ma};
                        r_div      <= w_mb;
                        r_q        <= '0;
                        r_special  <= w_spec;
                        r_sres     <= w_sres;
                        r_sflg     <= w_sflg;
                    end
                end
                S_DIV: begin
                    // The integer bit falls off the top after the last step.
                    r_q   <= {r_q[MAN_W-1:0], w_ge};
                    r_rem <= {w_nrem, 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(DIV_N - 1)) begin
                        r_state  <= S_ROUND;
                        r_rnd_ph <= 1'b0;
                    end
                end
                S_ROUND: begin
                    if (!r_rnd_ph) begin
                        r_rfrac   <= w_rfrac;
                        r_rcarry  <= w_rcarry;
                        r_inexact <= r_q[0] | w_sticky;
                        r_rnd_ph  <= 1'b1;
                    end else begin
                        r_result    <= w_pres;
                        r_flags     <= w_pflg;
                        r_out_valid <= 1'b1;
                        r_rnd_ph    <= 1'b0;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
